// File: rtl/sample_acquisition_az.sv
// Auto-zero acquisition sequencer: alternates HI (signal) and LO (zero) measurements,
// driving the AZ mux, the precharge switch and the trigger/valid handshake with the ADC block.
module sample_acquisition_az (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_measure_valid,
  input  logic        arm_trigger,
  input  logic [23:0] p_clk_count_precharge,
  input  logic [23:0] p_clk_count_settle,
  input  logic [3:0]  p_azmux_hi,
  input  logic [3:0]  p_azmux_lo,
  output logic        adc_measure_trig,
  output logic [3:0]  azmux,
  output logic        sw_pc,
  output logic        last_hi,
  output logic [23:0] pair_count,
  output logic        led0,
  output logic [3:0]  monitor
);

  typedef enum logic [3:0] {
    HI_PC_LOAD,
    HI_PC_WAIT,
    HI_SIG_LOAD,
    HI_SIG_WAIT,
    HI_TRIG,
    HI_WAIT,
    LO_PC_LOAD,
    LO_PC_WAIT,
    LO_TRIG,
    LO_WAIT,
    PARK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_arm_edge;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_trig;
  logic        w_trig_nxt;
  logic [3:0]  r_azmux;
  logic [3:0]  w_azmux_nxt;
  logic        r_sw_pc;
  logic        w_sw_pc_nxt;
  logic        r_last_hi;
  logic        w_last_hi_nxt;
  logic [23:0] r_pair_count;
  logic [23:0] w_pair_count_nxt;
  logic        r_led0;
  logic        w_led0_nxt;
  logic        w_cnt_zero;
  logic        w_ack;

  assign w_cnt_zero = (r_count == 32'd0);
  // valid low only counts as an ack once trig is already presented, so a valid that
  // is still low on TRIG entry yields a single-cycle trig pulse
  assign w_ack      = r_trig && !adc_measure_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HI_PC_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count - 32'd1;
    w_trig_nxt       = r_trig;
    w_azmux_nxt      = r_azmux;
    w_sw_pc_nxt      = r_sw_pc;
    w_last_hi_nxt    = r_last_hi;
    w_pair_count_nxt = r_pair_count;
    w_led0_nxt       = r_led0;
    case (r_state)
      HI_PC_LOAD: begin
        w_sw_pc_nxt = 1'b1;
        w_azmux_nxt = p_azmux_hi;
        w_count_nxt = {8'd0, p_clk_count_precharge};
        w_state_nxt = HI_PC_WAIT;
      end
      HI_PC_WAIT: begin
        if (w_cnt_zero) w_state_nxt = HI_SIG_LOAD;
      end
      HI_SIG_LOAD: begin
        w_sw_pc_nxt = 1'b0;
        w_count_nxt = {8'd0, p_clk_count_settle};
        w_state_nxt = HI_SIG_WAIT;
      end
      HI_SIG_WAIT: begin
        if (w_cnt_zero) w_state_nxt = HI_TRIG;
      end
      HI_TRIG: begin
        w_trig_nxt = 1'b1;
        if (w_ack) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (adc_measure_valid) begin
          w_last_hi_nxt = 1'b1;
          w_state_nxt   = LO_PC_LOAD;
        end
      end
      LO_PC_LOAD: begin
        w_sw_pc_nxt = 1'b1;
        w_azmux_nxt = p_azmux_lo;
        w_count_nxt = {8'd0, p_clk_count_precharge};
        w_state_nxt = LO_PC_WAIT;
      end
      LO_PC_WAIT: begin
        if (w_cnt_zero) w_state_nxt = LO_TRIG;
      end
      LO_TRIG: begin
        w_trig_nxt = 1'b1;
        if (w_ack) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = LO_WAIT;
        end
      end
      LO_WAIT: begin
        if (adc_measure_valid) begin
          w_last_hi_nxt    = 1'b0;
          w_pair_count_nxt = r_pair_count + 24'd1;
          w_led0_nxt       = ~r_led0;
          w_state_nxt      = HI_PC_LOAD;
        end
      end
      PARK: begin
        w_trig_nxt  = 1'b0;
        w_sw_pc_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = HI_PC_LOAD;
      end
    endcase
    // arm edges win over the case transition; other outputs of the case still apply
    if (r_arm_edge == 2'b01) begin
      w_state_nxt = HI_PC_LOAD;
      w_trig_nxt  = 1'b0;
    end else if (r_arm_edge == 2'b10) begin
      w_state_nxt = PARK;
      w_trig_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_arm_edge   <= 2'b00;
      r_count      <= 32'd0;
      r_trig       <= 1'b0;
      r_azmux      <= 4'd0;
      r_sw_pc      <= 1'b1;
      r_last_hi    <= 1'b0;
      r_pair_count <= 24'd0;
      r_led0       <= 1'b0;
    end else begin
      r_arm_edge   <= {r_arm_edge[0], arm_trigger};
      r_count      <= w_count_nxt;
      r_trig       <= w_trig_nxt;
      r_azmux      <= w_azmux_nxt;
      r_sw_pc      <= w_sw_pc_nxt;
      r_last_hi    <= w_last_hi_nxt;
      r_pair_count <= w_pair_count_nxt;
      r_led0       <= w_led0_nxt;
    end
  end

  assign adc_measure_trig = r_trig;
  assign azmux            = r_azmux;
  assign sw_pc            = r_sw_pc;
  assign last_hi          = r_last_hi;
  assign pair_count       = r_pair_count;
  assign led0             = r_led0;
  assign monitor          = {r_last_hi, r_sw_pc, adc_measure_valid, r_trig};

endmodule

// File: tb/tb_sample_acquisition_az.sv
// Scoreboard bench for sample_acquisition_az: a stimulus process queues expected measurements,
// an ADC behavioural model answers the handshake, and a negedge monitor pops and compares.
module tb_sample_acquisition_az;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_valid = 1'b1;
  logic        arm = 1'b0;
  logic [23:0] p_pre = 24'd0;
  logic [23:0] p_set = 24'd0;
  logic [3:0]  p_hi = 4'd0;
  logic [3:0]  p_lo = 4'd0;
  logic        trig;
  logic [3:0]  azmux;
  logic        sw_pc;
  logic        last_hi;
  logic [23:0] pair_count;
  logic        led0;
  logic [3:0]  mon;

  sample_acquisition_az dut (
    .clk(clk), .reset(rst), .adc_measure_valid(adc_valid), .arm_trigger(arm),
    .p_clk_count_precharge(p_pre), .p_clk_count_settle(p_set),
    .p_azmux_hi(p_hi), .p_azmux_lo(p_lo),
    .adc_measure_trig(trig), .azmux(azmux), .sw_pc(sw_pc), .last_hi(last_hi),
    .pair_count(pair_count), .led0(led0), .monitor(mon)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected at cycle %0d", name, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // expected measurement record, one per trig pulse
  typedef struct {
    bit          hi;
    logic [3:0]  mux;
    bit          use_ref;
    int          gap;
    int          gap_sw;
    logic [23:0] pc;
    bit          led;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  bit   has_cur = 0;
  bit   sb_en = 0;
  bit   chk_en = 0;
  int   t_ref = 0;
  int   t_cmpl = 0;
  int   t_sw = 0;
  int   n_pairs = 0;

  // ADC behaviour: 0 = never acks (valid stuck high), 1 = drop after d_drop, busy d_busy
  int adc_mode = 1;
  int d_drop = 1;
  int d_busy = 5;

  initial begin
    forever begin
      tick;
      if (adc_mode == 1 && trig && adc_valid) begin
        for (int i = 0; i < d_drop; i++) tick;
        adc_valid = 1'b0;
        for (int i = 0; i < d_busy; i++) tick;
        adc_valid = 1'b1;
      end
    end
  end

  logic p_trig = 1'b0;
  logic p_valid = 1'b1;
  logic p_sw = 1'b1;
  logic p_last = 1'b0;

  always @(negedge clk) begin
    if (chk_en && p_trig && !p_valid) check("trig_drop_after_ack", {31'd0, trig}, 32'd0);
    if (sb_en && trig && !p_trig) begin
      if (q.size() == 0) begin
        fail_evt("unexpected_trig");
        has_cur = 0;
      end else begin
        cur = q.pop_front();
        has_cur = 1;
        check(cur.hi ? "hi_azmux" : "lo_azmux", {28'd0, azmux}, {28'd0, cur.mux});
        check(cur.hi ? "hi_sw_pc" : "lo_sw_pc", {31'd0, sw_pc}, cur.hi ? 32'd0 : 32'd1);
        check(cur.hi ? "hi_trig_gap" : "lo_trig_gap",
              cyc - (cur.use_ref ? t_ref : t_cmpl), cur.gap);
        if (cur.hi) check("settle_gap", cyc - t_sw, cur.gap_sw);
      end
    end
    if (p_sw && !sw_pc) t_sw = cyc;
    if (last_hi != p_last) begin
      t_cmpl = cyc;
      if (sb_en) begin
        if (!has_cur) begin
          fail_evt("unexpected_done");
        end else begin
          check("done_kind", {31'd0, last_hi}, {31'd0, cur.hi});
          check("done_pair_count", {8'd0, pair_count}, {8'd0, cur.pc});
          check("done_led0", {31'd0, led0}, {31'd0, cur.led});
          has_cur = 0;
          if (!cur.hi) n_pairs++;
        end
      end
    end
    p_trig  = trig;
    p_valid = adc_valid;
    p_sw    = sw_pc;
    p_last  = last_hi;
  end

  int          P = 3;
  int          S = 2;
  logic [23:0] m_pc = 24'd0;
  bit          m_led = 0;

  task automatic apply_params(input int pre, input int set, input logic [3:0] hi, input logic [3:0] lo);
    P = pre;
    S = set;
    p_pre = pre[23:0];
    p_set = set[23:0];
    p_hi = hi;
    p_lo = lo;
  endtask

  // one HI+LO pair: HI trig is P+S+5 after the previous LO completion (or gap_first
  // after t_ref), LO trig is P+3 after the HI completion, settle-to-trig is S+2
  task automatic push_run(input int k, input int gap_first);
    rec_t r;
    for (int i = 0; i < k; i++) begin
      r.hi = 1; r.mux = p_hi; r.use_ref = (i == 0);
      r.gap = (i == 0) ? gap_first : P + S + 5;
      r.gap_sw = S + 2; r.pc = m_pc; r.led = m_led;
      q.push_back(r);
      m_pc = m_pc + 24'd1;
      m_led = ~m_led;
      r.hi = 0; r.mux = p_lo; r.use_ref = 0; r.gap = P + 3;
      r.gap_sw = 0; r.pc = m_pc; r.led = m_led;
      q.push_back(r);
    end
  endtask

  task automatic wait_run(input int target);
    int budget;
    budget = 5000;
    while (n_pairs < target && budget > 0) begin
      tick;
      budget--;
    end
    if (n_pairs < target) begin
      fail_evt("run_timeout");
      q.delete();
      n_pairs = target;
    end
    check("queue_drained", q.size(), 32'd0);
  endtask

  task automatic wait_trig;
    int budget;
    budget = 300;
    while (!trig && budget > 0) begin
      tick;
      budget--;
    end
    if (!trig) fail_evt("trig_timeout");
  endtask

  task automatic park_block;
    arm = 1'b0;
    repeat (5) tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_params(3, 2, 4'h5, 4'hA);
    repeat (3) tick;
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_azmux", {28'd0, azmux}, 32'd0);
    check("rst_sw_pc", {31'd0, sw_pc}, 32'd1);
    check("rst_last_hi", {31'd0, last_hi}, 32'd0);
    check("rst_pair_count", {8'd0, pair_count}, 32'd0);
    check("rst_led0", {31'd0, led0}, 32'd0);
    check("rst_monitor", {28'd0, mon}, 32'h6);
    chk_en = 1;
    sb_en = 1;

    // runs straight out of reset with arm low
    push_run(2, P + S + 5);
    rst = 1'b0;
    t_ref = cyc;
    wait_run(n_pairs + 2);

    // rising arm while running restarts with zero delays
    apply_params(0, 0, 4'h3, 4'hC);
    push_run(2, P + S + 7);
    arm = 1'b1;
    t_ref = cyc;
    wait_run(n_pairs + 2);

    for (int r = 0; r < 6; r++) begin
      park_block;
      apply_params($urandom_range(0, 5), $urandom_range(0, 5),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      d_drop = $urandom_range(0, 2);
      d_busy = $urandom_range(1, 6);
      push_run($urandom_range(1, 3), P + S + 7);
      arm = 1'b1;
      t_ref = cyc;
      wait_run(n_pairs + q.size() / 2);
    end

    // ADC never acks: trig holds, then a falling arm parks the block
    park_block;
    sb_en = 0;
    adc_mode = 0;
    apply_params(1, 1, 4'h9, 4'h6);
    arm = 1'b1;
    wait_trig;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (i % 8 == 7) check("stuck_trig_high", {31'd0, trig}, 32'd1);
    end
    arm = 1'b0;
    tick;
    check("park_trig_pending", {31'd0, trig}, 32'd1);
    tick;
    check("park_trig_drop", {31'd0, trig}, 32'd0);
    tick;
    check("park_sw_pc", {31'd0, sw_pc}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      tick;
      if (i % 10 == 9) begin
        check("park_hold_azmux", {28'd0, azmux}, 32'h9);
        check("park_hold_trig", {31'd0, trig}, 32'd0);
        check("park_hold_sw_pc", {31'd0, sw_pc}, 32'd1);
        check("park_hold_pair_count", {8'd0, pair_count}, {8'd0, m_pc});
        check("park_hold_led0", {31'd0, led0}, {31'd0, m_led});
        check("park_hold_monitor", {28'd0, mon}, 32'h6);
      end
    end

    // pair counter preloaded near the top, fast ADC, zero delays
    force dut.r_pair_count = 24'hFFFFFE;
    tick;
    release dut.r_pair_count;
    tick;
    m_pc = 24'hFFFFFE;
    adc_mode = 1;
    d_drop = 0;
    d_busy = 1;
    apply_params(0, 0, 4'h1, 4'h2);
    sb_en = 1;
    push_run(3, P + S + 7);
    arm = 1'b1;
    t_ref = cyc;
    wait_run(n_pairs + 3);
    park_block;
    check("wrap_final_count", {8'd0, pair_count}, 32'd1);

    // reset in the middle of a handshake
    sb_en = 0;
    adc_mode = 0;
    arm = 1'b1;
    wait_trig;
    tick;
    rst = 1'b1;
    tick;
    check("midrst_trig", {31'd0, trig}, 32'd0);
    check("midrst_sw_pc", {31'd0, sw_pc}, 32'd1);
    check("midrst_azmux", {28'd0, azmux}, 32'd0);
    check("midrst_pair_count", {8'd0, pair_count}, 32'd0);
    check("midrst_led0", {31'd0, led0}, 32'd0);
    check("midrst_last_hi", {31'd0, last_hi}, 32'd0);
    rst = 1'b0;
    repeat (3) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
